spio_hss_multiplexer_frame_rx: RTL and testbench
================================================

Name: spio_hss_multiplexer_frame_rx

Overview:
- Sits directly downstream of the rx control stage and consumes its aligned, filtered 32-bit word stream (data, charisk, valid).
- Delineates frames, buffers each payload, and checks CRC and sequence number.
- Releases validated payloads through a valid/ready interface and emits ACK/NACK pulses for the local transmitter.
- Only fully verified frames leave the block.

Parameters:
- MAX_WORDS, 8, maximum payload words per frame; the frame buffer depth.
- LEN_BITS, 3, width of the header length field (log2 MAX_WORDS).
- SEQ_BITS, 7, width of the frame sequence number (at most 8).

Ports:
- CLK_IN input 1: clock.
- RESET_IN input 1: asynchronous, active-high reset.
- LINK_UP_IN input 1: handshake-complete indication from rx control.
- RXDATA_IN input 32: aligned received word.
- RXCHARISK_IN input 4: K-char flags for RXDATA_IN.
- RXVLD_IN input 1: RXDATA_IN/RXCHARISK_IN valid this cycle.
- DATA_OUT output 32: payload word.
- LAST_OUT output 1: DATA_OUT is the final word of the frame.
- VLD_OUT output 1: DATA_OUT valid.
- RDY_IN input 1: consumer accepts DATA_OUT.
- ACK_OUT output 1: one-cycle pulse, frame SEQ_OUT accepted.
- NACK_OUT output 1: one-cycle pulse, resend from SEQ_OUT.
- SEQ_OUT output SEQ_BITS: sequence number for ACK/NACK.
- CRC_ERR_OUT output 1: one-cycle pulse on CRC failure.
- OVERRUN_OUT output 1: one-cycle pulse when a frame is dropped because the buffer is busy.

Behaviour:
- Clock and reset: one clock; reset asynchronous, active-high.
- Reset values: all outputs 0, state IDLE, expected seq 0, CRC register 0xFFFF.
- Frame format:
  - Header: charisk 4'b1000, byte3 KCH_SOF, byte2 seq (upper unused bits 0), byte1 length-1, byte0 0x00.
  - Payload: length words, charisk 4'b0000.
  - Trailer: charisk 4'b1000, byte3 KCH_EOF, byte2 0x00, bytes1..0 CRC.
- CRC: CRC-16-CCITT, poly 0x1021, init 0xFFFF, MSB first, over header and payload words (32 bits per word per cycle).
- RXVLD_IN low: the cycle is ignored in every state; FSM and CRC hold.
- States:
  - IDLE: a header word moves to PAYLOAD, sets word count 0, and loads CRC = f(0xFFFF, header). All other words are discarded.
  - PAYLOAD: each data word is written to buffer[count], count increments, CRC updates. After length words, move to TRAILER.
  - TRAILER: an EOF word is evaluated; the result pulses the cycle after the trailer.
    - CRC mismatch: CRC_ERR_OUT=1, NACK_OUT=1, SEQ_OUT=expected; go to IDLE.
    - Seq == expected: ACK_OUT=1, SEQ_OUT=seq, expected increments modulo 2^SEQ_BITS; go to DRAIN.
    - Seq == expected-1 (duplicate): ACK_OUT=1 with that seq; payload dropped; go to IDLE.
    - Any other seq: NACK_OUT=1, SEQ_OUT=expected; go to IDLE.
  - DRAIN: VLD_OUT=1 from the cycle after the trailer. Words are presented in order; DATA_OUT is held until RDY_IN. LAST_OUT=1 on word length-1. Acceptance of the last word returns to IDLE the next cycle.
- Abort conditions, each giving NACK_OUT=1 with SEQ_OUT=expected:
  - In PAYLOAD, any non-header word with charisk != 0: go to IDLE.
  - In TRAILER, any word other than EOF: go to IDLE.
  - A header in PAYLOAD or TRAILER: aborts the current frame and starts capture of the new frame in the same cycle.
- Header with length-1 >= MAX_WORDS (only possible when MAX_WORDS is not a power of 2): NACK; stay in IDLE.
- Header in DRAIN: OVERRUN_OUT=1 and NACK_OUT=1 with SEQ_OUT=expected. The rest of that frame is discarded as non-header words once back in IDLE. Drain continues unaffected.
- Pulse exclusivity: at most one of ACK_OUT/NACK_OUT per cycle, guaranteed by processing one word per cycle.
- LINK_UP_IN low: on the next edge, state goes to IDLE, expected seq 0, VLD_OUT 0, buffer contents discarded, no pulses.

Decomposition:
- Extend the shared common header with KCH_SOF and KCH_EOF (distinct from the comma, handshake and clock-correction K-chars), CRC_POLY 16'h1021, CRC_INIT 16'hFFFF, and the state encodings.
- Sub-module spio_hss_multiplexer_crc16_word: combinational next-CRC of a 16-bit CRC and a 32-bit word.

Test Plan:
- Clean frame: LINK_UP_IN=1, seq 0, length 3, words A,B,C, correct CRC -> ACK_OUT pulse with SEQ_OUT=0; A,B,C out in order with LAST_OUT on C; RDY_IN toggling every other cycle produces no loss or duplication.
- CRC error: same frame, one payload bit flipped -> CRC_ERR_OUT and NACK_OUT with SEQ_OUT=0; VLD_OUT stays 0. A resend of seq 0 is then ACKed.
- Sequence handling: after seq 0 ACKed, resend seq 0 -> ACK with SEQ_OUT=0, no output data. Then seq 5 -> NACK with SEQ_OUT=1.
- Overrun: hold RDY_IN=0 during drain, send the seq 1 frame -> OVERRUN_OUT and NACK with SEQ_OUT=1. After drain, a resent seq 1 is ACKed.
- Gaps and aborts: RXVLD_IN low between payload words -> same result as the clean frame. A K-char mid-payload -> NACK and return to IDLE. A header mid-payload -> old frame aborted, new frame ACKed.
- Link drop: deassert LINK_UP_IN mid-drain -> VLD_OUT 0 next cycle; a following frame with seq 0 is ACKed.

Source files
------------

// File: rtl/spio_hss_multiplexer_frame_rx_pkg.sv
// Shared constants for the HSS multiplexer frame receiver: frame K-chars, CRC settings, FSM states.
package spio_hss_multiplexer_frame_rx_pkg;

  // K27.7 / K29.7: kept apart from the comma, handshake and clock-correction K-chars
  localparam logic [7:0]  KCH_SOF      = 8'hFB;
  localparam logic [7:0]  KCH_EOF      = 8'hFD;
  localparam logic [3:0]  KCHARISK_CTL = 4'b1000;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_TRAILER,
    ST_DRAIN
  } rx_state_t;

endpackage

// File: rtl/spio_hss_multiplexer_crc16_word.sv
// Combinational CRC-16-CCITT update over one 32-bit word, MSB first.
module spio_hss_multiplexer_crc16_word
  import spio_hss_multiplexer_frame_rx_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [31:0] data,
  output logic [15:0] next_crc
);

  always_comb begin
    next_crc = crc;
    for (int unsigned i = 0; i < 32; i++) begin
      if (next_crc[15] ^ data[31 - i]) next_crc = {next_crc[14:0], 1'b0} ^ CRC_POLY;
      else                             next_crc = {next_crc[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/spio_hss_multiplexer_frame_rx.sv
// Frame receiver: delineates frames, buffers payload, verifies CRC and sequence,
// releases verified payloads over valid/ready and reports ACK/NACK to the transmitter.
module spio_hss_multiplexer_frame_rx
  import spio_hss_multiplexer_frame_rx_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 8,
  parameter int unsigned LEN_BITS  = 3,
  parameter int unsigned SEQ_BITS  = 7
) (
  input  logic                CLK_IN,
  input  logic                RESET_IN,
  input  logic                LINK_UP_IN,
  input  logic [31:0]         RXDATA_IN,
  input  logic [3:0]          RXCHARISK_IN,
  input  logic                RXVLD_IN,
  output logic [31:0]         DATA_OUT,
  output logic                LAST_OUT,
  output logic                VLD_OUT,
  input  logic                RDY_IN,
  output logic                ACK_OUT,
  output logic                NACK_OUT,
  output logic [SEQ_BITS-1:0] SEQ_OUT,
  output logic                CRC_ERR_OUT,
  output logic                OVERRUN_OUT
);

  rx_state_t           state;
  logic [31:0]         buffer [MAX_WORDS];
  logic [LEN_BITS-1:0] count, len_m1, rd_ptr;
  logic [SEQ_BITS-1:0] exp_seq, frm_seq;
  logic [15:0]         crc_q, crc_base, crc_next;

  logic                is_hdr, is_eof, hdr_len_ok;
  logic [LEN_BITS-1:0] hdr_len;
  logic [SEQ_BITS-1:0] hdr_seq;

  assign is_hdr     = (RXCHARISK_IN == KCHARISK_CTL) && (RXDATA_IN[31:24] == KCH_SOF);
  assign is_eof     = (RXCHARISK_IN == KCHARISK_CTL) && (RXDATA_IN[31:24] == KCH_EOF);
  assign hdr_len    = RXDATA_IN[8 +: LEN_BITS];
  assign hdr_seq    = RXDATA_IN[16 +: SEQ_BITS];
  assign hdr_len_ok = {{(32 - LEN_BITS){1'b0}}, hdr_len} < MAX_WORDS;

  // A header always restarts the checksum, whatever state it arrives in
  assign crc_base = is_hdr ? CRC_INIT : crc_q;

  spio_hss_multiplexer_crc16_word u_crc (
    .crc      (crc_base),
    .data     (RXDATA_IN),
    .next_crc (crc_next)
  );

  assign DATA_OUT = buffer[rd_ptr];
  assign LAST_OUT = VLD_OUT && (rd_ptr == len_m1);

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state       <= ST_IDLE;
      count       <= '0;
      len_m1      <= '0;
      rd_ptr      <= '0;
      exp_seq     <= '0;
      frm_seq     <= '0;
      crc_q       <= CRC_INIT;
      VLD_OUT     <= 1'b0;
      ACK_OUT     <= 1'b0;
      NACK_OUT    <= 1'b0;
      SEQ_OUT     <= '0;
      CRC_ERR_OUT <= 1'b0;
      OVERRUN_OUT <= 1'b0;
      for (int unsigned i = 0; i < MAX_WORDS; i++) buffer[i] <= '0;
    end else begin
      ACK_OUT     <= 1'b0;
      NACK_OUT    <= 1'b0;
      CRC_ERR_OUT <= 1'b0;
      OVERRUN_OUT <= 1'b0;
      if (!LINK_UP_IN) begin
        state   <= ST_IDLE;
        exp_seq <= '0;
        VLD_OUT <= 1'b0;
        rd_ptr  <= '0;
        count   <= '0;
        crc_q   <= CRC_INIT;
      end else begin
        if (VLD_OUT && RDY_IN) begin
          if (rd_ptr == len_m1) begin
            VLD_OUT <= 1'b0;
            rd_ptr  <= '0;
            state   <= ST_IDLE;
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
        if (RXVLD_IN) begin
          // Header handling is shared by IDLE/PAYLOAD/TRAILER; an in-flight frame is NACKed first
          if (is_hdr && state != ST_DRAIN) begin
            if (state != ST_IDLE || !hdr_len_ok) begin
              NACK_OUT <= 1'b1;
              SEQ_OUT  <= exp_seq;
            end
            if (hdr_len_ok) begin
              state   <= ST_PAYLOAD;
              count   <= '0;
              len_m1  <= hdr_len;
              frm_seq <= hdr_seq;
              crc_q   <= crc_next;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            case (state)
              ST_IDLE: ;
              ST_PAYLOAD: begin
                if (RXCHARISK_IN != 4'b0000) begin
                  NACK_OUT <= 1'b1;
                  SEQ_OUT  <= exp_seq;
                  state    <= ST_IDLE;
                end else begin
                  buffer[count] <= RXDATA_IN;
                  crc_q         <= crc_next;
                  count         <= count + 1'b1;
                  if (count == len_m1) state <= ST_TRAILER;
                end
              end
              ST_TRAILER: begin
                state <= ST_IDLE;
                if (!is_eof) begin
                  NACK_OUT <= 1'b1;
                  SEQ_OUT  <= exp_seq;
                end else if (RXDATA_IN[15:0] != crc_q) begin
                  CRC_ERR_OUT <= 1'b1;
                  NACK_OUT    <= 1'b1;
                  SEQ_OUT     <= exp_seq;
                end else if (frm_seq == exp_seq) begin
                  ACK_OUT <= 1'b1;
                  SEQ_OUT <= frm_seq;
                  exp_seq <= exp_seq + 1'b1;
                  VLD_OUT <= 1'b1;
                  rd_ptr  <= '0;
                  state   <= ST_DRAIN;
                end else if (frm_seq == exp_seq - 1'b1) begin
                  ACK_OUT <= 1'b1;
                  SEQ_OUT <= frm_seq;
                end else begin
                  NACK_OUT <= 1'b1;
                  SEQ_OUT  <= exp_seq;
                end
              end
              ST_DRAIN: begin
                if (is_hdr) begin
                  OVERRUN_OUT <= 1'b1;
                  NACK_OUT    <= 1'b1;
                  SEQ_OUT     <= exp_seq;
                end
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spio_hss_multiplexer_frame_rx.sv
// Scoreboard bench for the frame receiver: stimulus pushes expected pulses/words, a monitor pops and compares.
module tb_spio_hss_multiplexer_frame_rx;
  import spio_hss_multiplexer_frame_rx_pkg::*;

  logic        CLK_IN = 1'b0;
  logic        RESET_IN, LINK_UP_IN, RXVLD_IN, RDY_IN;
  logic [31:0] RXDATA_IN;
  logic [3:0]  RXCHARISK_IN;
  logic [31:0] DATA_OUT;
  logic        LAST_OUT, VLD_OUT, ACK_OUT, NACK_OUT, CRC_ERR_OUT, OVERRUN_OUT;
  logic [6:0]  SEQ_OUT;

  spio_hss_multiplexer_frame_rx #(.MAX_WORDS(8), .LEN_BITS(3), .SEQ_BITS(7)) dut (
    .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .LINK_UP_IN(LINK_UP_IN),
    .RXDATA_IN(RXDATA_IN), .RXCHARISK_IN(RXCHARISK_IN), .RXVLD_IN(RXVLD_IN),
    .DATA_OUT(DATA_OUT), .LAST_OUT(LAST_OUT), .VLD_OUT(VLD_OUT), .RDY_IN(RDY_IN),
    .ACK_OUT(ACK_OUT), .NACK_OUT(NACK_OUT), .SEQ_OUT(SEQ_OUT),
    .CRC_ERR_OUT(CRC_ERR_OUT), .OVERRUN_OUT(OVERRUN_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  typedef struct packed { logic ack; logic nack; logic crc_err; logic overrun; logic [6:0] seq; } ev_t;
  typedef struct packed { logic [31:0] d; logic last; } dw_t;

  ev_t exp_ev[$];
  dw_t exp_dat[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] pl [8];

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic step(logic [31:0] d, logic [3:0] k, logic v);
    RXDATA_IN = d; RXCHARISK_IN = k; RXVLD_IN = v;
    @(posedge CLK_IN); #1;
  endtask

  task automatic idle(int n);
    repeat (n) step(32'h0, 4'h0, 1'b0);
  endtask

  task automatic push_ev(logic ack, logic nack, logic crc_err, logic ovr, logic [6:0] seq);
    exp_ev.push_back('{ack: ack, nack: nack, crc_err: crc_err, overrun: ovr, seq: seq});
  endtask

  // Byte-at-a-time reference CRC-16-CCITT (init/poly applied by caller/here)
  function automatic logic [15:0] crc_word(logic [15:0] c, logic [31:0] w);
    logic [15:0] r;
    r = c;
    for (int b = 3; b >= 0; b--) begin
      r = r ^ {w[8*b +: 8], 8'h00};
      for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  task automatic send_frame(logic [6:0] seq, int len, bit corrupt, bit gaps, bit push_data);
    logic [31:0] hdr, w;
    logic [15:0] c;
    hdr = {KCH_SOF, 1'b0, seq, 8'(len - 1), 8'h00};
    c = crc_word(16'hFFFF, hdr);
    for (int i = 0; i < len; i++) c = crc_word(c, pl[i]);
    if (push_data)
      for (int i = 0; i < len; i++) exp_dat.push_back('{d: pl[i], last: (i == len - 1)});
    step(hdr, 4'b1000, 1'b1);
    for (int i = 0; i < len; i++) begin
      w = pl[i];
      if (corrupt && i == 1) w[5] = ~w[5];
      step(w, 4'b0000, 1'b1);
      if (gaps) idle(2);
    end
    step({KCH_EOF, 8'h00, c}, 4'b1000, 1'b1);
    idle(2);
  endtask

  task automatic drain_wait(bit toggle);
    int n;
    n = 0;
    while (exp_dat.size() != 0 && n < 100) begin
      RDY_IN = toggle ? ~RDY_IN : 1'b1;
      idle(1);
      n++;
    end
    check("drain_done_words_left", exp_dat.size(), 0);
    RDY_IN = 1'b1;
    idle(3);
  endtask

  // Monitor: every pulse and every accepted word must match the head of its queue
  always @(negedge CLK_IN) begin
    if (ACK_OUT || NACK_OUT || CRC_ERR_OUT || OVERRUN_OUT) begin
      if (exp_ev.size() == 0) begin
        checks++; failures++;
        $display("FAIL pulse_unexpected: got ack=%0b nack=%0b crc_err=%0b overrun=%0b seq=%0d required none",
                 ACK_OUT, NACK_OUT, CRC_ERR_OUT, OVERRUN_OUT, SEQ_OUT);
      end else begin
        ev_t e;
        e = exp_ev.pop_front();
        check("pulse{ack,nack,crc,ovr,seq}", 32'({ACK_OUT, NACK_OUT, CRC_ERR_OUT, OVERRUN_OUT, SEQ_OUT}), 32'(e));
      end
    end
    if (VLD_OUT && RDY_IN) begin
      if (exp_dat.size() == 0) begin
        checks++; failures++;
        $display("FAIL data_unexpected: got data=%h last=%0b required none", DATA_OUT, LAST_OUT);
      end else begin
        dw_t x;
        x = exp_dat.pop_front();
        check("data", DATA_OUT, x.d);
        check("last", 32'(LAST_OUT), 32'(x.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

  initial begin
    pl = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3,
           32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h55AA55AA};
    RESET_IN = 1'b1; LINK_UP_IN = 1'b1; RDY_IN = 1'b1;
    RXDATA_IN = '0; RXCHARISK_IN = '0; RXVLD_IN = 1'b0;
    repeat (3) @(posedge CLK_IN);
    #1 RESET_IN = 1'b0;
    @(negedge CLK_IN);
    check("reset_vld", 32'(VLD_OUT), 0);
    check("reset_pulses", 32'({ACK_OUT, NACK_OUT, CRC_ERR_OUT, OVERRUN_OUT}), 0);
    check("reset_seq", 32'(SEQ_OUT), 0);
    check("reset_data_last", {DATA_OUT[30:0], LAST_OUT}, 0);
    @(posedge CLK_IN); #1;

    // CRC error on seq 0: CRC_ERR + NACK(0), no data
    push_ev(0, 1, 1, 0, 7'd0);
    send_frame(7'd0, 3, 1'b1, 1'b0, 1'b0);

    // Clean seq 0, RDY toggling
    push_ev(1, 0, 0, 0, 7'd0);
    RDY_IN = 1'b0;
    send_frame(7'd0, 3, 1'b0, 1'b0, 1'b1);
    drain_wait(1'b1);

    // Duplicate seq 0 -> ACK(0) without data; seq 5 -> NACK(1)
    push_ev(1, 0, 0, 0, 7'd0);
    send_frame(7'd0, 3, 1'b0, 1'b0, 1'b0);
    push_ev(0, 1, 0, 0, 7'd1);
    send_frame(7'd5, 2, 1'b0, 1'b0, 1'b0);

    // RXVLD gaps between words -> ACK(1) with data
    push_ev(1, 0, 0, 0, 7'd1);
    send_frame(7'd1, 3, 1'b0, 1'b1, 1'b1);
    drain_wait(1'b0);

    // K-char mid-payload -> NACK(2)
    push_ev(0, 1, 0, 0, 7'd2);
    step({KCH_SOF, 8'd2, 8'd2, 8'h00}, 4'b1000, 1'b1);
    step(pl[0], 4'b0000, 1'b1);
    step(32'h000000BC, 4'b0001, 1'b1);
    idle(2);

    // Header mid-payload -> NACK(2), then new seq 2 frame ACKed
    push_ev(0, 1, 0, 0, 7'd2);
    push_ev(1, 0, 0, 0, 7'd2);
    step({KCH_SOF, 8'd2, 8'd2, 8'h00}, 4'b1000, 1'b1);
    step(pl[3], 4'b0000, 1'b1);
    send_frame(7'd2, 2, 1'b0, 1'b0, 1'b1);
    drain_wait(1'b0);

    // Overrun: seq 3 held in drain, seq 4 header arrives -> OVERRUN + NACK(4)
    RDY_IN = 1'b0;
    push_ev(1, 0, 0, 0, 7'd3);
    send_frame(7'd3, 2, 1'b0, 1'b0, 1'b1);
    push_ev(0, 1, 0, 1, 7'd4);
    send_frame(7'd4, 4, 1'b0, 1'b0, 1'b0);
    drain_wait(1'b0);
    push_ev(1, 0, 0, 0, 7'd4);
    send_frame(7'd4, 4, 1'b0, 1'b0, 1'b1);
    drain_wait(1'b0);

    // Link drop mid-drain: VLD falls, expected seq back to 0
    RDY_IN = 1'b0;
    push_ev(1, 0, 0, 0, 7'd5);
    send_frame(7'd5, 3, 1'b0, 1'b0, 1'b0);
    check("drain_held_vld", 32'(VLD_OUT), 1);
    LINK_UP_IN = 1'b0;
    idle(1);
    check("linkdrop_vld", 32'(VLD_OUT), 0);
    LINK_UP_IN = 1'b1;
    RDY_IN = 1'b1;
    push_ev(1, 0, 0, 0, 7'd0);
    send_frame(7'd0, 8, 1'b0, 1'b0, 1'b1);
    drain_wait(1'b0);

    check("pulses_left", exp_ev.size(), 0);
    check("words_left", exp_dat.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
